uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_tx` transmitter between `N_REQ` byte sources, such as the echo path, a status reporter and a debug dumper. Arbitration is round-robin with packet locking: once a requester wins, it keeps the transmitter until it sends a byte flagged `last`. The block sequences each byte: it accepts the byte, pulses the transmitter's enable, and waits for the transmitter to report completion. A lock watchdog frees the transmitter from a requester that stalls mid-packet. The block sits between the byte producers and `uart_tx`, in the same clock domain.

## Interface
- `N_REQ`, default 3: number of requesters (2..8).
- `PAYLOAD_BITS`, default 8: byte width; must match `uart_tx`.
- `LOCK_TIMEOUT`, default 50000: idle cycles a locked owner may stall before its lock is revoked; 0 disables the watchdog.
- `clk` in 1: system clock.
- `resetn` in 1: reset, synchronous and active-low.
- `req_valid` in N_REQ: requester i has a byte.
- `req_data` in N_REQ*PAYLOAD_BITS: byte of requester i, in slice [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- `req_last` in N_REQ: the byte of requester i ends its packet.
- `req_ready` out N_REQ: one-hot, single-cycle accept strobe.
- `uart_tx_en` out 1: start-transmission pulse to `uart_tx`.
- `uart_tx_data` out PAYLOAD_BITS: byte to `uart_tx`.
- `uart_tx_done` in 1: `uart_tx` has returned to idle; may be a pulse or a level.
- `grant` out N_REQ: one-hot current lock owner; all zero when unlocked.
- `busy` out 1: state is not IDLE.
- `lock_timeout` out 1: one-cycle pulse when a lock is revoked.

## Operation
- The FSM has four states: IDLE, LAUNCH, GUARD, WAIT.
- **IDLE, unlocked:**
  - Select the first i with `req_valid[i]=1`, scanning upward (modulo N_REQ) from priority pointer `ptr`.
  - Assert `req_ready[i]` combinationally in this cycle.
  - Register the byte and `last`.
  - Set `grant` to i.
  - Go to LAUNCH.
- **IDLE, locked to owner k:**
  - Only requester k is eligible.
  - If `req_valid[k]=1`, accept it as above.
  - Other requesters' `req_valid` is ignored.
- **Transfer:** a byte transfers only in a cycle where `req_valid[i]` and `req_ready[i]` are both 1. `req_ready` is 0 in every non-IDLE state.
- **LAUNCH:** `uart_tx_en`=1 for exactly this cycle. Go to GUARD.
- **GUARD:** `uart_tx_done` is ignored, which masks a stale idle level. Go to WAIT.
- **WAIT:** stay until `uart_tx_done`=1, then go to IDLE.
  - If the registered `last`=1, clear the lock (`grant`=0) and set `ptr`=(owner+1) mod N_REQ.
  - Otherwise keep the lock.
- **Watchdog:**
  - The counter increments each cycle the FSM is in IDLE, locked, with `req_valid[owner]`=0.
  - It clears on any accept.
  - When it reaches `LOCK_TIMEOUT`: clear the lock, set `ptr`=owner+1, pulse `lock_timeout`, clear the counter.
  - No byte is accepted in that cycle.
  - The watchdog is inactive when `LOCK_TIMEOUT`=0.
- **Counter width:** $clog2(LOCK_TIMEOUT+1), minimum 1.
- **`uart_tx_data`:** holds the last accepted byte until the next accept. It is 0 after reset.

## Timing
- **Reset values:** state IDLE, `ptr`=0, `grant`=0, `uart_tx_en`=0, `uart_tx_data`=0, `req_ready`=0, `busy`=0, `lock_timeout`=0, watchdog counter 0.
- **Reset mid-transfer:**
  - Resetting in any state returns the block to IDLE on the next edge.
  - The lock is dropped and no pending byte is resent.
  - `uart_tx` shares `resetn`.
- **Byte latency:** with accept at cycle T, `uart_tx_en`=1 at T+1. The earliest `uart_tx_done` is sampled at T+3. If done is seen at cycle D, the next accept is possible at D+1.
- **Throughput:** minimum 4 cycles per byte, plus the UART frame time.
- **Outputs:** `uart_tx_en`, `grant`, `busy`, `lock_timeout` and `uart_tx_data` are registered. `req_ready` is combinational from state, `grant`, `ptr` and `req_valid`.
- **Simultaneous events:**
  - If the owner's valid rises in the same cycle the watchdog expires, the timeout wins and the byte waits for re-arbitration.
  - If `uart_tx_done` and `resetn`=0 coincide, reset wins.
- **Wrap-around:** from `ptr`=N_REQ-1 the scan continues to requesters 0, 1, and so on.

## Test plan
- **Round-robin rotation:** N_REQ=3, all valid with `last`=1 and data 0xA0/0xB1/0xC2 -> `uart_tx_data` sequence A0, B1, C2, A0. Each `uart_tx_en` is 1 cycle wide, and each `req_ready` pulse is 1 cycle.
- **Packet lock:** requester 1 sends 3 bytes (11, 22, 33 with last on 33) while requester 0 holds valid -> bytes 11, 22, 33 go out uninterrupted, `grant`=3'b010 throughout, then requester 0 is served.
- **Launch latency:** single accept at T with `uart_tx_done` held at 1 -> `uart_tx_en` at T+1, `busy` drops at T+4, next `req_ready` possible at T+4.
- **Watchdog revoke:** LOCK_TIMEOUT=10; requester 2 sends a non-last byte, then drops valid -> `lock_timeout` pulses 10 cycles after entering IDLE, `grant`=0, and requester 0 wins next.
- **Wrap-around:** `ptr`=2 after requester 1 finishes, requesters 0 and 2 both valid -> 2 served first, then 0.
- **Mid-transfer reset:** `resetn`=0 for one cycle during WAIT -> all outputs return to reset values on the next edge, and no extra `uart_tx_en` occurs afterwards until a new request arrives.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// A winner keeps the transmitter until its 'last' byte; a watchdog revokes stalled locks.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned LOCK_TIMEOUT = 50000
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*PAYLOAD_BITS-1:0]   req_data,
    input  logic [N_REQ-1:0]                req_last,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_done,
    output logic [N_REQ-1:0]                grant,
    output logic                            busy,
    output logic                            lock_timeout
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_MAX   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic             WD_EN    = (LOCK_TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, LAUNCH, GUARD, WAIT} state_t;

    state_t                  state, state_n;
    logic [PTR_W-1:0]        ptr, owner, sel, next_ptr;
    logic [PTR_W:0]          sum;
    logic [CNT_W-1:0]        wd_cnt;
    logic [PAYLOAD_BITS-1:0] sel_byte;
    logic                    sel_last, last_q;
    logic                    locked, accept, expire, stall, found;

    assign locked   = |grant;
    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        sel       = '0;
        sum       = '0;
        accept    = 1'b0;
        expire    = 1'b0;
        stall     = 1'b0;
        found     = 1'b0;
        case (state)
            IDLE: begin
                if (locked) begin
                    // Expiry takes precedence over an owner byte arriving in the same cycle.
                    if (WD_EN && wd_cnt == WD_MAX) begin
                        expire = 1'b1;
                    end else if (req_valid[owner]) begin
                        accept = 1'b1;
                        sel    = owner;
                    end else begin
                        stall = 1'b1;
                    end
                end else begin
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        sum = {1'b0, ptr} + (PTR_W+1)'(k);
                        if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
                        if (!found && req_valid[sum[PTR_W-1:0]]) begin
                            found = 1'b1;
                            sel   = sum[PTR_W-1:0];
                        end
                    end
                    accept = found;
                end
                if (accept) begin
                    req_ready[sel] = 1'b1;
                    state_n        = LAUNCH;
                end
            end
            LAUNCH:  state_n = GUARD;
            // GUARD ignores done so a stale idle level from uart_tx cannot end WAIT early.
            GUARD:   state_n = WAIT;
            WAIT:    if (uart_tx_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (sel == PTR_W'(k)) begin
                sel_byte = req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
                sel_last = req_last[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr          <= '0;
            owner        <= '0;
            grant        <= '0;
            last_q       <= 1'b0;
            wd_cnt       <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            uart_tx_en   <= accept;
            lock_timeout <= expire;
            busy         <= (state_n != IDLE);
            if (accept) begin
                uart_tx_data <= sel_byte;
                last_q       <= sel_last;
                grant        <= ONE_HOT0 << sel;
                owner        <= sel;
                wd_cnt       <= '0;
            end else if (expire) begin
                grant  <= '0;
                ptr    <= next_ptr;
                wd_cnt <= '0;
            end else if (WD_EN && stall) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (state == WAIT && uart_tx_done && last_q) begin
                grant <= '0;
                ptr   <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected bytes/owners are queued with the stimulus
// and popped as each uart_tx_en launch is observed.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] req_valid, req_last, req_ready, grant;
    logic [23:0] req_data;
    logic       uart_tx_en, uart_tx_done, busy, lock_timeout;
    logic [7:0] uart_tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(3), .PAYLOAD_BITS(8), .LOCK_TIMEOUT(10)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_done(uart_tx_done),
        .grant(grant), .busy(busy), .lock_timeout(lock_timeout)
    );

    // Transmitter stand-in: done is a level, low for frame_len cycles after each launch.
    int unsigned frame_len = 3;
    int unsigned fcnt = 0;
    always @(posedge clk) begin
        if (!resetn)         fcnt <= 0;
        else if (uart_tx_en) fcnt <= frame_len;
        else if (fcnt != 0)  fcnt <= fcnt - 1;
    end
    assign uart_tx_done = (fcnt == 0);

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [10:0] exp_q[$];
    logic [8:0]  src_mem [3][16];
    int unsigned head [3];
    int unsigned tail [3];
    int unsigned acc_seen [3];
    int unsigned en_seen = 0;
    logic        prev_en = 1'b0;
    logic [2:0]  prev_ready = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic l);
        src_mem[i][tail[i] % 16] = {l, d};
        tail[i]++;
    endtask

    task automatic expect_tx(input logic [2:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic present();
        for (int i = 0; i < 3; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = src_mem[i][head[i] % 16][7:0];
                req_last[i]         = src_mem[i][head[i] % 16][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = '0;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic observe();
        logic [10:0] e;
        if (resetn) begin
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    head[i]++;
                    acc_seen[i]++;
                end
            end
            if (|req_ready) begin
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                check("ready_1cycle", 32'(|prev_ready), 0);
            end
            if (uart_tx_en) begin
                en_seen++;
                check("en_1cycle", 32'(prev_en), 0);
                check("en_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(uart_tx_data), 32'(e[7:0]));
                    check("tx_grant", 32'(grant), 32'(e[10:8]));
                end
            end
        end
        prev_en    = uart_tx_en;
        prev_ready = req_ready;
    endtask

    // One clock: new inputs just after the rising edge, sampling on the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        present();
        @(negedge clk);
        observe();
    endtask

    task automatic drain(input string tag);
        logic ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            cycle();
            if (exp_q.size() == 0 && !busy && head[0] == tail[0] &&
                head[1] == tail[1] && head[2] == tail[2]) ok = 1'b1;
        end
        check(tag, 32'(ok), 1);
    endtask

    task automatic wait_accept(input int i, input string tag);
        int unsigned a = acc_seen[i];
        for (int n = 0; n < 200 && acc_seen[i] == a; n++) cycle();
        check(tag, 32'(acc_seen[i] != a), 1);
    endtask

    initial begin
        int unsigned e0, a0;
        logic ok;
        for (int i = 0; i < 3; i++) begin
            head[i] = 0; tail[i] = 0; acc_seen[i] = 0;
        end
        resetn = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_en", 32'(uart_tx_en), 0);
        check("rst_data", 32'(uart_tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(lock_timeout), 0);
        check("rst_ready", 32'(req_ready), 0);
        resetn = 1'b1;

        // Round-robin rotation from ptr=0.
        frame_len = 3;
        load(0, 8'hA0, 1); load(0, 8'hA0, 1); load(1, 8'hB1, 1); load(2, 8'hC2, 1);
        expect_tx(3'b001, 8'hA0); expect_tx(3'b010, 8'hB1);
        expect_tx(3'b100, 8'hC2); expect_tx(3'b001, 8'hA0);
        drain("rr_drain");

        // Requester 1 alone moves ptr to 2, then 0 and 2 compete: 2 wins, then wrap to 0.
        load(1, 8'h55, 1); expect_tx(3'b010, 8'h55);
        drain("wrap_setup_drain");
        load(0, 8'h66, 1); load(2, 8'h77, 1);
        expect_tx(3'b100, 8'h77); expect_tx(3'b001, 8'h66);
        drain("wrap_drain");

        // Packet lock: with ptr=2, an unlocked scan would pick requester 0 over 1.
        load(1, 8'h88, 1); expect_tx(3'b010, 8'h88);
        drain("lock_setup_drain");
        load(1, 8'h11, 0); load(1, 8'h22, 0); load(1, 8'h33, 1);
        expect_tx(3'b010, 8'h11); expect_tx(3'b010, 8'h22);
        expect_tx(3'b010, 8'h33); expect_tx(3'b001, 8'h44);
        wait_accept(1, "lock_first_accept");
        load(0, 8'h44, 1);
        a0 = acc_seen[0];
        for (int n = 0; n < 300 && acc_seen[0] == a0; n++) begin
            cycle();
            if ((head[1] != tail[1] || busy) && acc_seen[0] == a0)
                check("lock_grant", 32'(grant), 32'(3'b010));
        end
        check("lock_r0_served", 32'(acc_seen[0] != a0), 1);
        drain("lock_drain");

        // Launch latency with done held high.
        frame_len = 0;
        load(0, 8'h5A, 1); load(0, 8'h5B, 1);
        expect_tx(3'b001, 8'h5A); expect_tx(3'b001, 8'h5B);
        wait_accept(0, "lat_accept");
        cycle();
        check("lat_en_t1", 32'(uart_tx_en), 1);
        check("lat_busy_t1", 32'(busy), 1);
        check("lat_ready_t1", 32'(req_ready), 0);
        cycle();
        check("lat_en_t2", 32'(uart_tx_en), 0);
        check("lat_busy_t2", 32'(busy), 1);
        cycle();
        check("lat_busy_t3", 32'(busy), 1);
        check("lat_ready_t3", 32'(req_ready), 0);
        cycle();
        check("lat_busy_t4", 32'(busy), 0);
        check("lat_ready_t4", 32'(req_ready), 32'(3'b001));
        drain("lat_drain");

        // Watchdog: requester 2 stalls mid-packet while requester 0 waits.
        frame_len = 2;
        load(2, 8'h99, 0); expect_tx(3'b100, 8'h99);
        wait_accept(2, "wd_accept");
        load(0, 8'hAB, 1); expect_tx(3'b001, 8'hAB);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            cycle();
            if (!busy) ok = 1'b1;
        end
        check("wd_reach_idle", 32'(ok), 1);
        check("wd_grant_held", 32'(grant), 32'(3'b100));
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("wd_early", 32'(lock_timeout), 0);
            check("wd_ready_blocked", 32'(req_ready), 0);
        end
        cycle();
        check("wd_pulse", 32'(lock_timeout), 1);
        check("wd_grant_clear", 32'(grant), 0);
        check("wd_r0_ready", 32'(req_ready), 32'(3'b001));
        cycle();
        check("wd_pulse_width", 32'(lock_timeout), 0);
        drain("wd_drain");

        // Reset during WAIT.
        frame_len = 5;
        load(1, 8'hC3, 1); expect_tx(3'b010, 8'hC3);
        e0 = en_seen;
        for (int n = 0; n < 50 && en_seen == e0; n++) cycle();
        check("mr_launch", en_seen, e0 + 1);
        cycle();
        cycle();
        check("mr_in_wait", 32'(busy), 1);
        resetn = 1'b0;
        cycle();
        check("mr_grant", 32'(grant), 0);
        check("mr_en", 32'(uart_tx_en), 0);
        check("mr_data", 32'(uart_tx_data), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_timeout", 32'(lock_timeout), 0);
        check("mr_ready", 32'(req_ready), 0);
        resetn = 1'b1;
        e0 = en_seen;
        repeat (20) cycle();
        check("mr_no_resend", en_seen, e0);
        load(0, 8'h3C, 1); load(1, 8'h3D, 1);
        expect_tx(3'b001, 8'h3C); expect_tx(3'b010, 8'h3D);
        drain("mr_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
